vote_session_ctrl: RTL and testbench

- Session controller and round-robin arbiter that lets N voting booths share the single candidate-tally datapath.
- Sequences the election session (idle, open, closing, closed) and serialises booth vote requests into one valid/ready vote stream.
- Counts accepted ballots and issues a clear strobe to the tally datapath.
- Sits between the booth front-ends and the counter/winner logic in the voting-machine top.

---
 rtl/vote_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/vote_session_ctrl.sv | 176 +++++++++++++++++
 tb/tb_vote_session_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared definitions for the voting-session controller: session state encoding
// and default datapath widths.
package vote_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPEN    = 2'd1,
        ST_CLOSING = 2'd2,
        ST_CLOSED  = 2'd3
    } vote_state_e;

    localparam int unsigned DEF_CAND_W = 2;
    localparam int unsigned DEF_TOT_W  = 12;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first unmasked requester at or after
// the pointer wins.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any_grant
);

    logic [N-1:0]  eligible_c;
    logic [IW-1:0] cand_c;

    // Walk the requesters starting at the pointer; the first eligible one wins.
    always_comb begin
        eligible_c = req & ~mask;
        grant      = '0;
        idx        = '0;
        any_grant  = 1'b0;
        cand_c     = '0;
        for (int i = 0; i < int'(N); i++) begin
            cand_c = IW'((32'(ptr) + 32'(i)) % N);
            if (!any_grant && eligible_c[cand_c]) begin
                any_grant     = 1'b1;
                grant[cand_c] = 1'b1;
                idx           = cand_c;
            end
        end
    end

endmodule

// File: rtl/vote_session_ctrl.sv
// Election session sequencer plus round-robin booth arbiter feeding a single
// valid/ready vote stream into the tally datapath.
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int unsigned N_BOOTHS  = 4,
    parameter int unsigned CAND_W    = DEF_CAND_W,
    parameter int unsigned TOT_W     = DEF_TOT_W,
    parameter int unsigned MAX_VOTES = 4095
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         open_cmd,
    input  logic                         close_cmd,
    input  logic                         clear_cmd,
    input  logic [N_BOOTHS-1:0]          booth_req,
    input  logic [N_BOOTHS*CAND_W-1:0]   booth_cand,
    output logic [N_BOOTHS-1:0]          booth_ack,
    output logic [N_BOOTHS-1:0]          booth_nack,
    output logic                         vote_valid,
    output logic [CAND_W-1:0]            vote_cand,
    input  logic                         vote_ready,
    output logic                         tally_clear,
    output logic [TOT_W-1:0]             total_votes,
    output logic [1:0]                   state,
    output logic                         session_done
);

    localparam int unsigned     IW      = (N_BOOTHS > 1) ? $clog2(N_BOOTHS) : 1;
    localparam logic [TOT_W-1:0] MAX_CNT = TOT_W'(MAX_VOTES);
    localparam logic [IW-1:0]    LAST_ID = IW'(N_BOOTHS - 1);

    vote_state_e             state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [IW-1:0]           gnt_idx_q, gnt_idx_d;
    logic [N_BOOTHS-1:0]     gnt_oh_q, gnt_oh_d;
    logic                    valid_q, valid_d;
    logic [CAND_W-1:0]       cand_q, cand_d;
    logic [N_BOOTHS-1:0]     ack_q, ack_d;
    logic [N_BOOTHS-1:0]     nack_q, nack_d;
    logic                    clr_q, clr_d;
    logic [TOT_W-1:0]        total_q, total_d;
    logic                    done_q, done_d;

    logic [N_BOOTHS-1:0]     arb_grant;
    logic [IW-1:0]           arb_idx;
    logic                    arb_any;
    logic                    arb_en_c;
    logic                    handshake_c;
    logic [CAND_W-1:0]       cand_sel_c;
    logic [IW-1:0]           ptr_inc_c;

    // The booth acked last cycle is masked so a lingering req is not a second ballot.
    rr_arbiter #(
        .N (N_BOOTHS)
    ) u_arb (
        .req       (booth_req),
        .mask      (ack_q),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .idx       (arb_idx),
        .any_grant (arb_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            gnt_oh_q  <= '0;
            valid_q   <= 1'b0;
            cand_q    <= '0;
            ack_q     <= '0;
            nack_q    <= '0;
            clr_q     <= 1'b0;
            total_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_oh_q  <= gnt_oh_d;
            valid_q   <= valid_d;
            cand_q    <= cand_d;
            ack_q     <= ack_d;
            nack_q    <= nack_d;
            clr_q     <= clr_d;
            total_q   <= total_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_oh_d    = gnt_oh_q;
        valid_d     = valid_q;
        cand_d      = cand_q;
        ack_d       = '0;
        nack_d      = (state_q != ST_OPEN) ? booth_req : '0;
        clr_d       = 1'b0;
        total_d     = total_q;
        done_d      = 1'b0;

        handshake_c = valid_q & vote_ready;
        arb_en_c    = (state_q == ST_OPEN) && !valid_q && !close_cmd && !clear_cmd;
        ptr_inc_c   = (gnt_idx_q == LAST_ID) ? '0 : gnt_idx_q + IW'(1);

        cand_sel_c  = '0;
        for (int i = 0; i < int'(N_BOOTHS); i++) begin
            if (arb_grant[i]) begin
                cand_sel_c = booth_cand[i*CAND_W +: CAND_W];
            end
        end

        if (clear_cmd) begin
            // Clear aborts any pending vote without acking or counting it.
            state_d = ST_IDLE;
            ptr_d   = '0;
            valid_d = 1'b0;
            total_d = '0;
            clr_d   = 1'b1;
        end else begin
            if (handshake_c) begin
                valid_d = 1'b0;
                ack_d   = gnt_oh_q;
                ptr_d   = ptr_inc_c;
                if (total_q != MAX_CNT) begin
                    total_d = total_q + TOT_W'(1);
                end
            end else if (arb_en_c && arb_any) begin
                valid_d   = 1'b1;
                cand_d    = cand_sel_c;
                gnt_idx_d = arb_idx;
                gnt_oh_d  = arb_grant;
            end

            case (state_q)
                ST_IDLE: begin
                    if (open_cmd && !close_cmd) begin
                        state_d = ST_OPEN;
                    end
                end
                ST_OPEN: begin
                    if (close_cmd || (handshake_c && (total_q == MAX_CNT - TOT_W'(1)))) begin
                        state_d = ST_CLOSING;
                    end
                end
                ST_CLOSING: begin
                    if (!valid_q) begin
                        state_d = ST_CLOSED;
                    end
                end
                ST_CLOSED: begin
                    state_d = ST_CLOSED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        done_d = (state_d == ST_CLOSED);
    end

    assign booth_ack    = ack_q;
    assign booth_nack   = nack_q;
    assign vote_valid   = valid_q;
    assign vote_cand    = cand_q;
    assign tally_clear  = clr_q;
    assign total_votes  = total_q;
    assign state        = state_q;
    assign session_done = done_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl: a default build and a MAX_VOTES=3 build share
// stimulus and are both checked against a ballot-level model every cycle.
module tb_vote_session_ctrl;

    localparam int NB = 4;

    logic       clk = 1'b0;
    logic       rst_n, open_cmd, close_cmd, clear_cmd, vote_ready;
    logic [3:0] booth_req;
    logic [7:0] booth_cand;

    logic [3:0]  d_ack   [2];
    logic [3:0]  d_nack  [2];
    logic        d_valid [2];
    logic [1:0]  d_cand  [2];
    logic        d_clr   [2];
    logic [11:0] d_total [2];
    logic [1:0]  d_state [2];
    logic        d_done  [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vote_session_ctrl dut (
        .clk(clk), .rst_n(rst_n), .open_cmd(open_cmd), .close_cmd(close_cmd),
        .clear_cmd(clear_cmd), .booth_req(booth_req), .booth_cand(booth_cand),
        .booth_ack(d_ack[0]), .booth_nack(d_nack[0]), .vote_valid(d_valid[0]),
        .vote_cand(d_cand[0]), .vote_ready(vote_ready), .tally_clear(d_clr[0]),
        .total_votes(d_total[0]), .state(d_state[0]), .session_done(d_done[0])
    );

    vote_session_ctrl #(.MAX_VOTES(3)) dut_m3 (
        .clk(clk), .rst_n(rst_n), .open_cmd(open_cmd), .close_cmd(close_cmd),
        .clear_cmd(clear_cmd), .booth_req(booth_req), .booth_cand(booth_cand),
        .booth_ack(d_ack[1]), .booth_nack(d_nack[1]), .vote_valid(d_valid[1]),
        .vote_cand(d_cand[1]), .vote_ready(vote_ready), .tally_clear(d_clr[1]),
        .total_votes(d_total[1]), .state(d_state[1]), .session_done(d_done[1])
    );

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[inst%0d]: got %0h expected %0h", nm, k, act, exp);
        end
    endtask

    // Ballot-level model: session phase, who owns the offered ballot, and counts.
    int         e_state [2], e_ptr [2], e_owner [2], e_total [2];
    logic       e_valid [2], e_clr [2], e_done [2];
    logic [1:0] e_cand  [2];
    logic [3:0] e_ack   [2], e_nack [2];
    bit         model_live = 1'b0;

    always @(posedge clk) begin
        int mx, os, ot, b, pick;
        logic ov, hs;
        logic [3:0] avail;
        model_live = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mx = (k == 0) ? 4095 : 3;
            if (!rst_n) begin
                e_state[k] = 0; e_ptr[k] = 0; e_owner[k] = 0; e_total[k] = 0;
                e_valid[k] = 0; e_clr[k] = 0; e_done[k] = 0; e_cand[k] = 0;
                e_ack[k] = 0; e_nack[k] = 0;
            end else begin
                os = e_state[k]; ov = e_valid[k]; ot = e_total[k];
                hs = ov && vote_ready;
                e_nack[k] = (os != 1) ? booth_req : 4'b0;
                avail = booth_req & ~e_ack[k];
                e_ack[k] = 4'b0;
                e_clr[k] = 1'b0;
                if (clear_cmd) begin
                    e_state[k] = 0; e_valid[k] = 0; e_total[k] = 0; e_ptr[k] = 0; e_clr[k] = 1;
                end else begin
                    if (hs) begin
                        e_valid[k] = 0;
                        e_ack[k]   = 4'(1 << e_owner[k]);
                        if (ot < mx) e_total[k] = ot + 1;
                        e_ptr[k]   = (e_owner[k] + 1) % NB;
                    end else if (os == 1 && !ov && !close_cmd) begin
                        pick = -1;
                        for (int j = 0; j < NB; j++) begin
                            b = (e_ptr[k] + j) % NB;
                            if (pick < 0 && avail[b]) pick = b;
                        end
                        if (pick >= 0) begin
                            e_valid[k] = 1;
                            e_owner[k] = pick;
                            e_cand[k]  = booth_cand[pick*2 +: 2];
                        end
                    end
                    if (os == 0 && open_cmd && !close_cmd) e_state[k] = 1;
                    else if (os == 1 && (close_cmd || (hs && ot + 1 == mx))) e_state[k] = 2;
                    else if (os == 2 && !ov) e_state[k] = 3;
                end
                e_done[k] = (e_state[k] == 3);
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            for (int k = 0; k < 2; k++) begin
                check("state", k, 32'(d_state[k]), 32'(e_state[k]));
                check("vote_valid", k, 32'(d_valid[k]), 32'(e_valid[k]));
                check("vote_cand", k, 32'(d_cand[k]), 32'(e_cand[k]));
                check("booth_ack", k, 32'(d_ack[k]), 32'(e_ack[k]));
                check("booth_nack", k, 32'(d_nack[k]), 32'(e_nack[k]));
                check("tally_clear", k, 32'(d_clr[k]), 32'(e_clr[k]));
                check("total_votes", k, 32'(d_total[k]), 32'(e_total[k]));
                check("session_done", k, 32'(d_done[k]), 32'(e_done[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n = 0; open_cmd = 0; close_cmd = 0; clear_cmd = 0; vote_ready = 0;
        booth_req = 0; booth_cand = 0;
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            check("rst_state", k, 32'(d_state[k]), 32'd0);
            check("rst_valid", k, 32'(d_valid[k]), 32'd0);
            check("rst_total", k, 32'(d_total[k]), 32'd0);
            check("rst_clr", k, 32'(d_clr[k]), 32'd0);
        end
        rst_n = 1;
        tick();

        // Single vote from booth 2, candidate 3.
        open_cmd = 1; tick();
        check("t1_open", 0, 32'(d_state[0]), 32'd1);
        open_cmd = 0; booth_req = 4'b0100; booth_cand = 8'h30; vote_ready = 1;
        tick();
        check("t1_valid", 0, 32'(d_valid[0]), 32'd1);
        check("t1_cand", 0, 32'(d_cand[0]), 32'd3);
        tick();
        check("t1_ack", 0, 32'(d_ack[0]), 32'b0100);
        check("t1_total", 0, 32'(d_total[0]), 32'd1);
        booth_req = 0;
        tick();

        // Clear, reopen, all booths requesting continuously.
        clear_cmd = 1; tick();
        check("t2_clr", 0, 32'(d_clr[0]), 32'd1);
        check("t2_clr_total", 0, 32'(d_total[0]), 32'd0);
        clear_cmd = 0; tick();
        check("t2_clr_pulse", 0, 32'(d_clr[0]), 32'd0);
        open_cmd = 1; tick();
        open_cmd = 0; booth_req = 4'hF; booth_cand = 8'hE4; vote_ready = 1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c % 2 == 0) check("t2_ack_order", 0, 32'(d_ack[0]), 32'(1 << order[c/2 - 1]));
            else            check("t2_ack_gap", 0, 32'(d_ack[0]), 32'd0);
            if (c == 6) begin
                check("t6_closing", 1, 32'(d_state[1]), 32'd2);
                check("t6_total", 1, 32'(d_total[1]), 32'd3);
            end
        end
        check("t2_total", 0, 32'(d_total[0]), 32'd5);
        check("t6_closed", 1, 32'(d_state[1]), 32'd3);
        check("t6_done", 1, 32'(d_done[1]), 32'd1);
        check("t6_total_sat", 1, 32'(d_total[1]), 32'd3);
        check("t6_nack", 1, 32'(d_nack[1]), 32'hF);
        booth_req = 0;

        // Request while IDLE is rejected; opening clears the reject.
        clear_cmd = 1; tick();
        clear_cmd = 0; tick();
        booth_req = 4'b0010; booth_cand = 8'h08; vote_ready = 0;
        tick();
        check("t3_nack", 0, 32'(d_nack[0]), 32'b0010);
        check("t3_novalid", 0, 32'(d_valid[0]), 32'd0);
        open_cmd = 1; tick();
        open_cmd = 0; tick();
        check("t3_nack_open", 0, 32'(d_nack[0]), 32'd0);
        check("t3_valid", 0, 32'(d_valid[0]), 32'd1);
        check("t3_cand", 0, 32'(d_cand[0]), 32'd2);

        // Close while a vote is pending: vote completes, then CLOSED.
        close_cmd = 1; booth_req = 0; tick();
        check("t4_closing", 0, 32'(d_state[0]), 32'd2);
        check("t4_held", 0, 32'(d_valid[0]), 32'd1);
        close_cmd = 0; vote_ready = 1; tick();
        check("t4_ack", 0, 32'(d_ack[0]), 32'b0010);
        check("t4_total", 0, 32'(d_total[0]), 32'd1);
        tick();
        check("t4_closed", 0, 32'(d_state[0]), 32'd3);
        check("t4_done", 0, 32'(d_done[0]), 32'd1);
        tick();
        vote_ready = 0;

        // Clear coinciding with ready discards the pending vote.
        clear_cmd = 1; tick();
        clear_cmd = 0; open_cmd = 1; tick();
        open_cmd = 0; booth_req = 4'b1000; booth_cand = 8'h40; tick();
        check("t5_cand", 0, 32'(d_cand[0]), 32'd1);
        booth_req = 0; tick();
        clear_cmd = 1; vote_ready = 1; tick();
        check("t5_noack", 0, 32'(d_ack[0]), 32'd0);
        check("t5_total", 0, 32'(d_total[0]), 32'd0);
        check("t5_clr", 0, 32'(d_clr[0]), 32'd1);
        check("t5_idle", 0, 32'(d_state[0]), 32'd0);
        check("t5_valid", 0, 32'(d_valid[0]), 32'd0);
        clear_cmd = 0; vote_ready = 0; tick();
        check("t5_clr_once", 0, 32'(d_clr[0]), 32'd0);

        // close beats open when both arrive in IDLE.
        open_cmd = 1; close_cmd = 1; tick();
        check("prio_idle", 0, 32'(d_state[0]), 32'd0);
        open_cmd = 0; close_cmd = 0;

        // Reset mid-session with a vote pending.
        open_cmd = 1; tick();
        open_cmd = 0; booth_req = 4'b0001; booth_cand = 8'h01; tick();
        rst_n = 0; booth_req = 0; tick();
        check("rst_mid_valid", 0, 32'(d_valid[0]), 32'd0);
        check("rst_mid_state", 0, 32'(d_state[0]), 32'd0);
        check("rst_mid_clr", 0, 32'(d_clr[0]), 32'd0);
        rst_n = 1; tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
